// File: rtl/image_sdram_writer_pkg.sv
// -----------------------------------------------------------------------------
// image_sdram_writer_pkg
//   Shared video constants and types for the SDRAM image path. The per-line
//   video fetch (reader) and the image loader (writer) both derive their word
//   layout from these constants, so the two sides cannot drift apart.
//
//   Contents:
//     IMAGE_WIDTH / IMAGE_HEIGHT / BYTES_PER_PIXEL : raw image geometry
//     WORDS_PER_LINE : 16-bit SDRAM words per image line
//     writer_state_e : image writer control states
//     count_width()  : width of the word counters for a given word total
// -----------------------------------------------------------------------------
package image_sdram_writer_pkg;

  localparam int IMAGE_WIDTH     = 720;
  localparam int IMAGE_HEIGHT    = 720;
  localparam int BYTES_PER_PIXEL = 3;

  // One 16-bit word carries one background byte and one mask byte, so a line
  // needs one word per colour byte.
  localparam int WORDS_PER_LINE  = IMAGE_WIDTH * BYTES_PER_PIXEL;

  localparam int SDRAM_ADDR_W    = 25;
  localparam int SDRAM_WORD_W    = 16;
  localparam int MIN_COUNT_W     = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } writer_state_e;

  // Counters must hold the value TOTAL itself, and never shrink below the
  // width the full-size image needs.
  function automatic int count_width(input int total);
    int w;
    w = $clog2(total + 1);
    return (w > MIN_COUNT_W) ? w : MIN_COUNT_W;
  endfunction

endpackage

// File: rtl/image_sdram_writer_word_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo
//   Small synchronous FIFO for packed {mask, background} words. The head is
//   visible combinationally (first-word fall-through) so the writer can load
//   its request register from it on the same edge it pops.
//
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     clear_i      : synchronous flush (takes priority over push/pop)
//     push_i       : write push_data_i (ignored when full)
//     push_data_i  : word to enqueue
//     pop_i        : drop the head word (ignored when empty)
//     head_o       : current head word (valid when !empty_o)
//     count_o      : number of words stored
//     full_o       : count_o == DEPTH
//     empty_o      : count_o == 0
// -----------------------------------------------------------------------------
module word_fifo #(
  parameter int DEPTH = 4,   // power of two, at least 2
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // NOTE: every variable gets a default before any condition, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; a word is only ever read after it
  // was written, because count_q gates every pop and the head is ignored when
  // empty. Leaving it unreset lets it map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/image_sdram_writer.sv
// -----------------------------------------------------------------------------
// image_sdram_writer
//   Loads the background and mask images into SDRAM in the interleaved layout
//   the per-line video fetch reads back. The input byte stream alternates
//   background / mask bytes; each pair becomes one 16-bit word
//   {mask, background}, passes through a small FIFO and is written at
//   consecutive word addresses from BASE_ADDR with a request/ack handshake.
//
//   Ports (all in the clk_sys_131_072 domain):
//     clk_sys_131_072 : system clock
//     reset_n         : asynchronous active-low reset
//     start           : one-cycle pulse, begins a load (ignored while busy)
//     in_valid/in_byte: byte stream, even index = background, odd = mask
//     in_ready        : a byte is accepted this cycle when in_valid is high
//     busy            : load or drain in progress
//     done            : all words written (held until the next start)
//     overflow        : a byte was offered while in_ready was low in LOAD
//     sd_wr           : write request, held until sd_wr_ack
//     sd_wr_addr      : SDRAM word address
//     sd_wr_data      : {mask byte, background byte}
//     sd_wr_ack       : one-cycle pulse, request accepted
// -----------------------------------------------------------------------------
module image_sdram_writer #(
  parameter int          WORDS_PER_LINE = image_sdram_writer_pkg::WORDS_PER_LINE,
  parameter int          LINES          = image_sdram_writer_pkg::IMAGE_HEIGHT,
  parameter logic [24:0] BASE_ADDR      = 25'h0,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk_sys_131_072,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        sd_wr,
  output logic [24:0] sd_wr_addr,
  output logic [15:0] sd_wr_data,
  input  logic        sd_wr_ack
);

  import image_sdram_writer_pkg::*;

  localparam int               TOTAL   = WORDS_PER_LINE * LINES;
  localparam int               CNT_W   = count_width(TOTAL);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam int               FC_W    = $clog2(FIFO_DEPTH) + 1;

  writer_state_e state_q, state_d;

  logic             phase_q,       phase_d;
  logic [7:0]       bg_hold_q,     bg_hold_d;
  logic [CNT_W-1:0] push_count_q,  push_count_d;
  logic [CNT_W-1:0] write_count_q, write_count_d;
  logic             overflow_q,    overflow_d;
  logic             sd_wr_q,       sd_wr_d;
  logic [24:0]      sd_wr_addr_q,  sd_wr_addr_d;
  logic [15:0]      sd_wr_data_q,  sd_wr_data_d;

  logic             start_load;
  logic             accept;
  logic             fifo_push;
  logic             issue;
  logic             acked;
  logic [15:0]      fifo_head;
  logic [FC_W-1:0]  fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // A load begins only from a quiescent state; start while busy is dropped.
  assign start_load = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept     = in_valid && in_ready;
  // fifo_full is already excluded by in_ready; the extra term keeps the push
  // qualified locally for anyone reading the FIFO hookup in isolation.
  assign fifo_push  = accept && phase_q && !fifo_full;
  assign issue      = !sd_wr_q && !fifo_empty;
  assign acked      = sd_wr_q && sd_wr_ack;

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SDRAM_WORD_W)
  ) u_word_fifo (
    .clk         (clk_sys_131_072),
    .rst_n       (reset_n),
    .clear_i     (start_load),
    .push_i      (fifo_push),
    .push_data_i ({in_byte, bg_hold_q}),
    .pop_i       (issue),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk_sys_131_072 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (push_count_q == TOTAL_C) state_d = DRAIN;
      // The last request must be acknowledged before the load is complete.
      DRAIN:   if ((write_count_q == TOTAL_C) && !sd_wr_q) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == LOAD) || (state_q == DRAIN);
    done     = (state_q == DONE);
    in_ready = (state_q == LOAD) && (fifo_count < FC_W'(FIFO_DEPTH))
               && (push_count_q < TOTAL_C);
  end

  // ----------------------------------------------------------- datapath ----
  always_comb begin
    phase_d       = phase_q;
    bg_hold_d     = bg_hold_q;
    push_count_d  = push_count_q;
    write_count_d = write_count_q;
    overflow_d    = overflow_q;
    sd_wr_d       = sd_wr_q;
    sd_wr_addr_d  = sd_wr_addr_q;
    sd_wr_data_d  = sd_wr_data_q;

    if (start_load) begin
      phase_d       = 1'b0;
      push_count_d  = '0;
      write_count_d = '0;
      overflow_d    = 1'b0;
    end else begin
      // Input side: pair up background and mask bytes.
      if (accept) begin
        if (!phase_q) begin
          bg_hold_d = in_byte;
          phase_d   = 1'b1;
        end else begin
          phase_d      = 1'b0;
          push_count_d = push_count_q + CNT_W'(1);
        end
      end
      if ((state_q == LOAD) && in_valid && !in_ready) overflow_d = 1'b1;

      // Output side: issue and ack are exclusive since both depend on sd_wr_q.
      if (acked) begin
        sd_wr_d       = 1'b0;
        write_count_d = write_count_q + CNT_W'(1);
      end
      if (issue) begin
        sd_wr_d      = 1'b1;
        sd_wr_data_d = fifo_head;
        sd_wr_addr_d = BASE_ADDR + 25'(write_count_q);
      end
    end
  end

  always_ff @(posedge clk_sys_131_072 or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= 1'b0;
      bg_hold_q     <= '0;
      push_count_q  <= '0;
      write_count_q <= '0;
      overflow_q    <= 1'b0;
      sd_wr_q       <= 1'b0;
      sd_wr_addr_q  <= '0;
      sd_wr_data_q  <= '0;
    end else begin
      phase_q       <= phase_d;
      bg_hold_q     <= bg_hold_d;
      push_count_q  <= push_count_d;
      write_count_q <= write_count_d;
      overflow_q    <= overflow_d;
      sd_wr_q       <= sd_wr_d;
      sd_wr_addr_q  <= sd_wr_addr_d;
      sd_wr_data_q  <= sd_wr_data_d;
    end
  end

  assign overflow   = overflow_q;
  assign sd_wr      = sd_wr_q;
  assign sd_wr_addr = sd_wr_addr_q;
  assign sd_wr_data = sd_wr_data_q;

endmodule

// File: tb/tb_image_sdram_writer.sv
// -----------------------------------------------------------------------------
// tb_image_sdram_writer
//   Directed bench for image_sdram_writer with a 3x2-word image (TOTAL=6) at
//   BASE_ADDR=100. A background responder acknowledges each request one cycle
//   after it appears and logs the accepted address/data pairs.
// -----------------------------------------------------------------------------
module tb_image_sdram_writer;

  localparam int          N_WORDS = 6;
  localparam logic [24:0] BASE    = 25'd100;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        sd_wr;
  logic [24:0] sd_wr_addr;
  logic [15:0] sd_wr_data;
  logic        sd_wr_ack;

  logic        ack_en;
  logic [24:0] log_addr[$];
  logic [15:0] log_data[$];

  int errors = 0;
  int checks = 0;

  image_sdram_writer #(
    .WORDS_PER_LINE (3),
    .LINES          (2),
    .BASE_ADDR      (BASE),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk_sys_131_072 (clk),
    .reset_n         (reset_n),
    .start           (start),
    .in_valid        (in_valid),
    .in_byte         (in_byte),
    .in_ready        (in_ready),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .sd_wr           (sd_wr),
    .sd_wr_addr      (sd_wr_addr),
    .sd_wr_data      (sd_wr_data),
    .sd_wr_ack       (sd_wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers a byte only while in_ready is high, so waiting never counts as
  // an overflow.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      in_valid = 1'b0;
      tick();
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      in_valid = 1'b1;
      in_byte  = b;
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic send_range(input logic [7:0] first, input int count);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < count; i++) begin
      send_byte(b);
      b = b + 8'd1;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // Expected: word i at BASE+i, data {first+2i+1, first+2i}.
  task automatic check_writes(input string tag, input logic [7:0] first);
    logic [7:0] lo;
    logic [7:0] hi;
    check({tag, "_count"}, log_addr.size(), N_WORDS);
    for (int i = 0; i < N_WORDS && i < log_addr.size(); i++) begin
      lo = first + 8'(2 * i);
      hi = lo + 8'd1;
      check($sformatf("%s_addr%0d", tag, i), {7'd0, log_addr[i]}, {7'd0, BASE + 25'(i)});
      check($sformatf("%s_data%0d", tag, i), {16'd0, log_data[i]}, {16'd0, hi, lo});
    end
  endtask

  // Responder: acknowledge one cycle after a request appears and log it.
  initial begin
    sd_wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en) begin
        if (sd_wr && !sd_wr_ack) begin
          sd_wr_ack = 1'b1;
          log_addr.push_back(sd_wr_addr);
          log_data.push_back(sd_wr_data);
        end else begin
          sd_wr_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    ack_en   = 1'b0;
    tick();
    tick();
    tick();

    // Reset state.
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_sd_wr",    {31'd0, sd_wr},    32'd0);
    check("rst_addr",     {7'd0, sd_wr_addr}, 32'd0);
    check("rst_data",     {16'd0, sd_wr_data}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Ignored events in IDLE: a byte and a stray ack.
    in_valid  = 1'b1;
    in_byte   = 8'h55;
    sd_wr_ack = 1'b1;
    tick();
    in_valid  = 1'b0;
    sd_wr_ack = 1'b0;
    check("idle_overflow", {31'd0, overflow}, 32'd0);
    check("idle_busy",     {31'd0, busy},     32'd0);
    check("idle_sd_wr",    {31'd0, sd_wr},    32'd0);

    // Nominal load.
    clear_log();
    ack_en = 1'b1;
    pulse_start();
    check("nom_busy", {31'd0, busy}, 32'd1);
    send_range(8'h00, 2 * N_WORDS);
    wait_done();
    check_writes("nom", 8'h00);
    check("nom_busy_end", {31'd0, busy},     32'd0);
    check("nom_overflow", {31'd0, overflow}, 32'd0);

    // Restart from DONE with a stray ack and a start during LOAD.
    clear_log();
    ack_en    = 1'b0;
    sd_wr_ack = 1'b0;
    pulse_start();
    check("rs_done_low", {31'd0, done}, 32'd0);
    check("rs_busy",     {31'd0, busy}, 32'd1);
    sd_wr_ack = 1'b1;
    tick();
    sd_wr_ack = 1'b0;
    ack_en    = 1'b1;
    send_range(8'h20, 6);
    pulse_start();
    check("rs_busy_mid", {31'd0, busy}, 32'd1);
    send_range(8'h26, 6);
    check("rs_done_pending", {31'd0, done}, 32'd0);
    wait_done();
    check_writes("rs", 8'h20);

    // Back-pressure and overflow.
    clear_log();
    ack_en    = 1'b0;
    sd_wr_ack = 1'b0;
    pulse_start();
    send_range(8'h00, 10);
    tick();
    tick();
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_sd_wr",    {31'd0, sd_wr},    32'd1);
    check("bp_addr",     {7'd0, sd_wr_addr}, {7'd0, BASE});
    check("bp_data",     {16'd0, sd_wr_data}, 32'h0100);
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    tick();
    in_valid = 1'b0;
    check("ovf_set", {31'd0, overflow}, 32'd1);
    ack_en = 1'b1;
    send_range(8'h0A, 2);
    wait_done();
    check_writes("bp", 8'h00);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Next start clears overflow; then reset mid-load.
    clear_log();
    pulse_start();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    send_range(8'h00, 6);
    for (int n = 0; n < 50 && log_addr.size() < 3; n++) tick();
    check("mid_words", log_addr.size(), 3);
    #2;
    reset_n   = 1'b0;
    ack_en    = 1'b0;
    sd_wr_ack = 1'b0;
    #1;
    check("arst_sd_wr",    {31'd0, sd_wr},    32'd0);
    check("arst_busy",     {31'd0, busy},     32'd0);
    check("arst_done",     {31'd0, done},     32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_addr",     {7'd0, sd_wr_addr}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    clear_log();
    ack_en = 1'b1;
    pulse_start();
    send_range(8'h00, 2 * N_WORDS);
    wait_done();
    check_writes("post_rst", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
